bus_arbiter: RTL and testbench

- Sequences the single shared memory bus between the instruction-fetch master (ibus, IF stage) and the data master (dbus, MEM stage).
- Drives a registered cyc/stb bus with ack handshake and an ack watchdog.
- Raises per-master stall requests towards the pipeline control block.
- Holds each completed result until the owning stage is released by the global stall vector.

---
 rtl/bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one memory bus between the instruction-fetch master (ibus, IF
//   stage) and the data master (dbus, MEM stage). The bus request is
//   registered (cyc/stb, write enable, byte lanes, address, write data) and
//   completes on mem_ack or on an ack watchdog. A completed result is held
//   until the owning pipeline stage is released by the stall vector.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   stall[5:0]            pipeline stall vector (bit1 = IF, bit4 = MEM)
//   flush                 cancels an in-flight or held ibus result
//   ibus_*                fetch request/address in, read data/stall out
//   dbus_*                load/store request, lanes, address, data in;
//                         read data/stall out
//   mem_*                 registered bus outputs, mem_read_data/mem_ack in
//   bus_error             one-cycle pulse when the watchdog expires
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        ibus_request,
  input  logic [31:0] ibus_address,
  output logic [31:0] ibus_read_data,
  output logic        ibus_stall_request,
  input  logic        dbus_request,
  input  logic        dbus_write_enable,
  input  logic [3:0]  dbus_select,
  input  logic [31:0] dbus_address,
  input  logic [31:0] dbus_write_data,
  output logic [31:0] dbus_read_data,
  output logic        dbus_stall_request,
  output logic        mem_cyc_stb,
  output logic        mem_write_enable,
  output logic [3:0]  mem_select,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    IDLE,
    IBUS_ACCESS,
    DBUS_ACCESS,
    IBUS_HOLD,
    DBUS_HOLD
  } state_t;

  // The counter holds the number of ack-less cycles already spent, so the
  // access expires in the cycle where it would reach TIMEOUT_CYCLES.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  count;
  logic [31:0] ibus_hold;
  logic [31:0] dbus_hold;

  logic        in_access;
  logic        expired;
  logic        done;
  logic        grant_dbus;
  logic        grant_ibus;
  logic [31:0] bus_data;

  // Only the IF and MEM stall bits matter to this block.
  logic        unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

  assign in_access  = (state == IBUS_ACCESS) || (state == DBUS_ACCESS);
  // A same-cycle ack wins over the watchdog.
  assign expired    = in_access && !mem_ack && (count == LIMIT);
  assign done       = in_access && (mem_ack || expired);
  assign bus_data   = mem_ack ? mem_read_data : 32'h0;
  assign grant_dbus = (state == IDLE) && dbus_request;
  assign grant_ibus = (state == IDLE) && !dbus_request && ibus_request && !flush;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_dbus)      state_next = DBUS_ACCESS;
        else if (grant_ibus) state_next = IBUS_ACCESS;
      end
      IBUS_ACCESS: begin
        // A flushed fetch still finishes on the bus but is never held.
        if (done) state_next = (stall[1] && !flush) ? IBUS_HOLD : IDLE;
      end
      DBUS_ACCESS: begin
        if (done) state_next = stall[4] ? DBUS_HOLD : IDLE;
      end
      IBUS_HOLD: begin
        if (!stall[1] || flush) state_next = IDLE;
      end
      DBUS_HOLD: begin
        if (!stall[4]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Watchdog restarts on every completion and outside access states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 8'h0;
    end else if (done || !in_access) begin
      count <= 8'h0;
    end else begin
      count <= count + 8'h1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ibus_hold <= 32'h0;
      dbus_hold <= 32'h0;
    end else if (done) begin
      if (state == IBUS_ACCESS) ibus_hold <= bus_data;
      if (state == DBUS_ACCESS) dbus_hold <= bus_data;
    end
  end

  // Bus outputs are registered: a grant in IDLE shows up on the bus one
  // cycle later, and a completion clears the bus at the next edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_cyc_stb      <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_select       <= 4'h0;
      mem_address      <= 32'h0;
      mem_write_data   <= 32'h0;
    end else if (grant_dbus) begin
      mem_cyc_stb      <= 1'b1;
      mem_write_enable <= dbus_write_enable;
      mem_select       <= dbus_select;
      mem_address      <= dbus_address;
      mem_write_data   <= dbus_write_data;
    end else if (grant_ibus) begin
      mem_cyc_stb      <= 1'b1;
      mem_write_enable <= 1'b0;
      mem_select       <= 4'b1111;
      mem_address      <= ibus_address;
      mem_write_data   <= 32'h0;
    end else if (done) begin
      mem_cyc_stb      <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_select       <= 4'h0;
      mem_address      <= 32'h0;
      mem_write_data   <= 32'h0;
    end
  end

  always_comb begin
    ibus_read_data = 32'h0;
    dbus_read_data = 32'h0;
    if (state == IBUS_ACCESS && done) ibus_read_data = bus_data;
    else if (state == IBUS_HOLD)      ibus_read_data = ibus_hold;
    if (state == DBUS_ACCESS && done) dbus_read_data = bus_data;
    else if (state == DBUS_HOLD)      dbus_read_data = dbus_hold;
  end

  assign ibus_stall_request = ibus_request && !flush &&
                              !((state == IBUS_ACCESS) && done) &&
                              (state != IBUS_HOLD);
  assign dbus_stall_request = dbus_request &&
                              !((state == DBUS_ACCESS) && done) &&
                              (state != DBUS_HOLD);
  assign bus_error = expired;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        ibus_request = 1'b0;
  logic [31:0] ibus_address = '0;
  logic [31:0] ibus_read_data;
  logic        ibus_stall_request;
  logic        dbus_request = 1'b0;
  logic        dbus_write_enable = 1'b0;
  logic [3:0]  dbus_select = '0;
  logic [31:0] dbus_address = '0;
  logic [31:0] dbus_write_data = '0;
  logic [31:0] dbus_read_data;
  logic        dbus_stall_request;
  logic        mem_cyc_stb;
  logic        mem_write_enable;
  logic [3:0]  mem_select;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_ack = 1'b0;
  logic        bus_error;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .ibus_request(ibus_request), .ibus_address(ibus_address),
    .ibus_read_data(ibus_read_data), .ibus_stall_request(ibus_stall_request),
    .dbus_request(dbus_request), .dbus_write_enable(dbus_write_enable),
    .dbus_select(dbus_select), .dbus_address(dbus_address),
    .dbus_write_data(dbus_write_data), .dbus_read_data(dbus_read_data),
    .dbus_stall_request(dbus_stall_request), .mem_cyc_stb(mem_cyc_stb),
    .mem_write_enable(mem_write_enable), .mem_select(mem_select),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  st;   logic fl;  logic ir;  logic [31:0] ia;
    logic dr;  logic dw;  logic [3:0] ds;  logic [31:0] da;  logic [31:0] dd;
    logic [31:0] mr;   logic ak;
    logic ec;  logic ew;  logic [3:0] es;  logic [31:0] ea;  logic [31:0] ed;
    logic [31:0] eir;  logic eis;  logic [31:0] edr;  logic eds;  logic eb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  string tag = "reset";

  localparam logic [5:0]  ST1 = 6'b000010;
  localparam logic [5:0]  ST4 = 6'b011111;
  localparam logic [3:0]  F   = 4'b1111;
  localparam logic [31:0] Z   = 32'h0;

  task automatic v(input logic [5:0] st, input logic fl, input logic ir,
                   input logic [31:0] ia, input logic dr, input logic dw,
                   input logic [3:0] ds, input logic [31:0] da,
                   input logic [31:0] dd, input logic [31:0] mr, input logic ak,
                   input logic ec, input logic ew, input logic [3:0] es,
                   input logic [31:0] ea, input logic [31:0] ed,
                   input logic [31:0] eir, input logic eis,
                   input logic [31:0] edr, input logic eds, input logic eb);
    vec_t t;
    t.st = st; t.fl = fl; t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw;
    t.ds = ds; t.da = da; t.dd = dd; t.mr = mr; t.ak = ak;
    t.ec = ec; t.ew = ew; t.es = es; t.ea = ea; t.ed = ed;
    t.eir = eir; t.eis = eis; t.edr = edr; t.eds = eds; t.eb = eb;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic chk_all(input vec_t t);
    chk("mem_cyc_stb", 32'(mem_cyc_stb), 32'(t.ec));
    chk("mem_write_enable", 32'(mem_write_enable), 32'(t.ew));
    chk("mem_select", 32'(mem_select), 32'(t.es));
    chk("mem_address", mem_address, t.ea);
    chk("mem_write_data", mem_write_data, t.ed);
    chk("ibus_read_data", ibus_read_data, t.eir);
    chk("ibus_stall_request", 32'(ibus_stall_request), 32'(t.eis));
    chk("dbus_read_data", dbus_read_data, t.edr);
    chk("dbus_stall_request", 32'(dbus_stall_request), 32'(t.eds));
    chk("bus_error", 32'(bus_error), 32'(t.eb));
  endtask

  initial begin
    vec_t zero;
    zero = '{default: '0};

    // Reset values, then a plain idle cycle.
    #2 chk_all(zero);
    v(0,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    // Single fetch, slave acks on the 3rd cyc cycle.
    v(0,0,1,32'h100,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,1,Z,0,0);
    v(0,0,1,32'h100,0,0,0,Z,Z,Z,0, 1,0,F,32'h100,Z, Z,1,Z,0,0);
    v(0,0,1,32'h100,0,0,0,Z,Z,Z,0, 1,0,F,32'h100,Z, Z,1,Z,0,0);
    v(0,0,1,32'h100,0,0,0,Z,Z,32'h24020001,1, 1,0,F,32'h100,Z, 32'h24020001,0,Z,0,0);
    v(0,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    // Contention: dbus store first, ibus granted from IDLE afterwards.
    v(0,0,1,32'h104,1,1,4'h3,32'h2000,32'hDEADBEEF,Z,0, 0,0,0,Z,Z, Z,1,Z,1,0);
    v(0,0,1,32'h104,1,1,4'h3,32'h2000,32'hDEADBEEF,Z,0, 1,1,4'h3,32'h2000,32'hDEADBEEF, Z,1,Z,1,0);
    v(0,0,1,32'h104,1,1,4'h3,32'h2000,32'hDEADBEEF,Z,1, 1,1,4'h3,32'h2000,32'hDEADBEEF, Z,1,Z,0,0);
    v(0,0,1,32'h104,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,1,Z,0,0);
    v(0,0,1,32'h104,0,0,0,Z,Z,32'hCAFE0001,1, 1,0,F,32'h104,Z, 32'hCAFE0001,0,Z,0,0);
    v(0,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    // dbus hold with MEM stalled; ibus waits until the hold exits.
    v(0,0,0,Z,1,0,F,32'h3000,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,1,0);
    v(0,0,0,Z,1,0,F,32'h3000,Z,Z,0, 1,0,F,32'h3000,Z, Z,0,Z,1,0);
    v(ST4,0,0,Z,1,0,F,32'h3000,Z,32'h12345678,1, 1,0,F,32'h3000,Z, Z,0,32'h12345678,0,0);
    v(ST4,0,0,Z,1,0,F,32'h3000,Z,32'hFFFFFFFF,0, 0,0,0,Z,Z, Z,0,32'h12345678,0,0);
    v(ST4,0,1,32'h108,1,0,F,32'h3000,Z,32'hFFFFFFFF,0, 0,0,0,Z,Z, Z,1,32'h12345678,0,0);
    v(0,0,1,32'h108,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,1,32'h12345678,0,0);
    v(0,0,1,32'h108,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,1,Z,0,0);
    v(0,0,1,32'h108,0,0,0,Z,Z,32'h11112222,1, 1,0,F,32'h108,Z, 32'h11112222,0,Z,0,0);
    v(0,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    // Flush mid fetch: bus completes, no hold even with IF stalled.
    v(0,0,1,32'h10C,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,1,Z,0,0);
    v(0,0,1,32'h10C,0,0,0,Z,Z,Z,0, 1,0,F,32'h10C,Z, Z,1,Z,0,0);
    v(ST1,1,1,32'h10C,0,0,0,Z,Z,Z,0, 1,0,F,32'h10C,Z, Z,0,Z,0,0);
    v(ST1,1,1,32'h10C,0,0,0,Z,Z,32'h55556666,1, 1,0,F,32'h10C,Z, 32'h55556666,0,Z,0,0);
    v(ST1,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    // ibus hold with IF stalled, released by flush.
    v(0,0,1,32'h110,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,1,Z,0,0);
    v(ST1,0,1,32'h110,0,0,0,Z,Z,32'h77778888,1, 1,0,F,32'h110,Z, 32'h77778888,0,Z,0,0);
    v(ST1,0,1,32'h110,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, 32'h77778888,0,Z,0,0);
    v(ST1,1,1,32'h110,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, 32'h77778888,0,Z,0,0);
    v(0,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    // Watchdog expiry on the 4th access cycle, data forced to 0.
    v(0,0,0,Z,1,0,F,32'h4000,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,1,0);
    for (int k = 0; k < 3; k++)
      v(0,0,0,Z,1,0,F,32'h4000,Z,32'hABCDABCD,0, 1,0,F,32'h4000,Z, Z,0,Z,1,0);
    v(0,0,0,Z,1,0,F,32'h4000,Z,32'hABCDABCD,0, 1,0,F,32'h4000,Z, Z,0,Z,0,1);
    v(0,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    // Ack on the 4th cycle beats the watchdog.
    v(0,0,0,Z,1,0,F,32'h4000,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,1,0);
    for (int k = 0; k < 3; k++)
      v(0,0,0,Z,1,0,F,32'h4000,Z,Z,0, 1,0,F,32'h4000,Z, Z,0,Z,1,0);
    v(0,0,0,Z,1,0,F,32'h4000,Z,32'h00009999,1, 1,0,F,32'h4000,Z, Z,0,32'h00009999,0,0);
    v(0,0,0,Z,0,0,0,Z,Z,Z,0, 0,0,0,Z,Z, Z,0,Z,0,0);

    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      stall = vecs[i].st; flush = vecs[i].fl;
      ibus_request = vecs[i].ir; ibus_address = vecs[i].ia;
      dbus_request = vecs[i].dr; dbus_write_enable = vecs[i].dw;
      dbus_select = vecs[i].ds; dbus_address = vecs[i].da;
      dbus_write_data = vecs[i].dd;
      mem_read_data = vecs[i].mr; mem_ack = vecs[i].ak;
      #1;
      tag = $sformatf("row%0d", i);
      chk_all(vecs[i]);
    end

    // Reset in the middle of a dbus access.
    tag = "rst_mid";
    @(negedge clock);
    dbus_request = 1'b1; dbus_write_enable = 1'b0; dbus_select = F;
    dbus_address = 32'h5000; mem_ack = 1'b0; mem_read_data = Z;
    @(negedge clock); #1 chk("cyc_access1", 32'(mem_cyc_stb), 32'd1);
    @(negedge clock); #1 chk("cyc_access2", 32'(mem_cyc_stb), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("cyc_async_clear", 32'(mem_cyc_stb), 32'd0);
    chk("addr_async_clear", mem_address, Z);
    chk("sel_async_clear", 32'(mem_select), 32'd0);
    chk("berr_in_reset", 32'(bus_error), 32'd0);
    chk("dstall_in_reset", 32'(dbus_stall_request), 32'd1);
    chk("drd_in_reset", dbus_read_data, Z);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("cyc_after_release", 32'(mem_cyc_stb), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock); #1;
      chk($sformatf("cyc_regrant%0d", k), 32'(mem_cyc_stb), 32'd1);
      chk($sformatf("berr_fresh%0d", k), 32'(bus_error), 32'(k == 4));
    end
    @(negedge clock);
    dbus_request = 1'b0;
    #1 chk("cyc_after_timeout", 32'(mem_cyc_stb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
